// File: rtl/nfu_2a_pkg.sv
// Shared widths, schedule-entry field offsets and state encoding for the NFU-2A
// multiplier-reuse control sequencer.
package nfu_2a_pkg;

  localparam int unsigned TN           = 16;
  localparam int unsigned ADDR_SIZE    = 2;
  localparam int unsigned L1_SEL_WIDTH = 4;
  localparam int unsigned L2_SEL_WIDTH = 5;
  localparam int unsigned SCHED_AW     = 4;
  localparam int unsigned SCHED_DEPTH  = 1 << SCHED_AW;
  localparam int unsigned LEN_W        = SCHED_AW + 1;
  localparam int unsigned REPS_W       = 8;

  localparam int unsigned L1_W = TN * L1_SEL_WIDTH;
  localparam int unsigned L2_W = TN * L2_SEL_WIDTH;
  localparam int unsigned AD_W = TN * ADDR_SIZE;

  localparam int unsigned ENTRY_W =
    TN * (L1_SEL_WIDTH + L2_SEL_WIDTH + 2 * ADDR_SIZE + 1);

  // Entry fields are packed LSB-first in this order.
  localparam int unsigned L1_OFF = 0;
  localparam int unsigned L2_OFF = L1_OFF + L1_W;
  localparam int unsigned RD_OFF = L2_OFF + L2_W;
  localparam int unsigned WR_OFF = RD_OFF + AD_W;
  localparam int unsigned WE_OFF = WR_OFF + AD_W;

  typedef struct packed {
    logic [TN-1:0]   we;
    logic [AD_W-1:0] wr_addr;
    logic [AD_W-1:0] rd_addr;
    logic [L2_W-1:0] l2_sel;
    logic [L1_W-1:0] l1_sel;
  } step_out_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nfu_2a_sched_mem.sv
// Schedule table: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module nfu_2a_sched_mem
  import nfu_2a_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [SCHED_AW-1:0] waddr,
  input  logic [ENTRY_W-1:0]  wdata,
  input  logic [SCHED_AW-1:0] raddr,
  output logic [ENTRY_W-1:0]  rdata_c
);

  logic [ENTRY_W-1:0] mem_q [SCHED_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/nfu_2a_ctrl.sv
// NFU-2A reuse-stage sequencer: plays a loaded schedule one step per valid
// multiplier beat for a programmable number of passes.
module nfu_2a_ctrl
  import nfu_2a_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cfg_we,
  input  logic [SCHED_AW-1:0] i_cfg_addr,
  input  logic [ENTRY_W-1:0]  i_cfg_data,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_len,
  input  logic [REPS_W-1:0]   i_reps,
  input  logic                i_step_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cfg_err,
  output logic                o_valid,
  output logic [L1_W-1:0]     o_l1_sel_lines,
  output logic [L2_W-1:0]     o_l2_sel_lines,
  output logic [AD_W-1:0]     o_buf_read_addr,
  output logic [AD_W-1:0]     o_buf_write_addr,
  output logic [TN-1:0]       o_write_en
);

  state_t              state, state_next;
  logic [SCHED_AW-1:0] ptr_q, ptr_nx;
  logic [REPS_W-1:0]   rep_q, rep_nx;
  logic [REPS_W-1:0]   reps_q, reps_nx;
  logic [LEN_W-1:0]    len_q, len_nx;
  logic                busy_nx, done_nx, err_nx, valid_nx;
  step_out_t           out_q, out_nx;
  logic [ENTRY_W-1:0]  entry_c;
  logic                start_ok_c, last_ptr_c, last_rep_c, tbl_we_c;

  assign start_ok_c = (i_len != '0) && (i_len <= LEN_W'(SCHED_DEPTH)) &&
                      (i_reps != '0);
  assign last_ptr_c = (LEN_W'(ptr_q) == len_q - LEN_W'(1));
  assign last_rep_c = (rep_q == reps_q - REPS_W'(1));
  // Table writes are only accepted while idle.
  assign tbl_we_c   = i_cfg_we && (state == ST_IDLE);

  nfu_2a_sched_mem u_mem (
    .clk     (clk),
    .we      (tbl_we_c),
    .waddr   (i_cfg_addr),
    .wdata   (i_cfg_data),
    .raddr   (ptr_q),
    .rdata_c (entry_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (i_start && start_ok_c) state_next = ST_RUN;
      ST_RUN:  if (i_step_valid && last_ptr_c && last_rep_c) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values for counters and output registers; lines hold across stalls.
  always_comb begin
    ptr_nx   = ptr_q;
    rep_nx   = rep_q;
    len_nx   = len_q;
    reps_nx  = reps_q;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    out_nx   = out_q;
    out_nx.we = '0;
    // Busy stays up through the cycle that carries o_done.
    busy_nx  = (state == ST_RUN) || (state_next == ST_RUN);
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (start_ok_c) begin
            len_nx  = i_len;
            reps_nx = i_reps;
            ptr_nx  = '0;
            rep_nx  = '0;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      ST_RUN: begin
        err_nx = i_cfg_we;
        if (i_step_valid) begin
          valid_nx       = 1'b1;
          out_nx.l1_sel  = entry_c[L1_OFF +: L1_W];
          out_nx.l2_sel  = entry_c[L2_OFF +: L2_W];
          out_nx.rd_addr = entry_c[RD_OFF +: AD_W];
          out_nx.wr_addr = entry_c[WR_OFF +: AD_W];
          out_nx.we      = entry_c[WE_OFF +: TN];
          if (last_ptr_c) begin
            ptr_nx = '0;
            rep_nx = rep_q + REPS_W'(1);
            done_nx = last_rep_c;
          end else begin
            ptr_nx = ptr_q + SCHED_AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rep_q     <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;
      o_valid   <= 1'b0;
      out_q     <= '0;
    end else begin
      ptr_q     <= ptr_nx;
      rep_q     <= rep_nx;
      len_q     <= len_nx;
      reps_q    <= reps_nx;
      o_busy    <= busy_nx;
      o_done    <= done_nx;
      o_cfg_err <= err_nx;
      o_valid   <= valid_nx;
      out_q     <= out_nx;
    end
  end

  assign o_l1_sel_lines   = out_q.l1_sel;
  assign o_l2_sel_lines   = out_q.l2_sel;
  assign o_buf_read_addr  = out_q.rd_addr;
  assign o_buf_write_addr = out_q.wr_addr;
  assign o_write_en       = out_q.we;

endmodule

// File: tb/tb_nfu_2a_ctrl.sv
// Scoreboard bench for nfu_2a_ctrl: stimulus pushes expected beats, a negedge
// monitor pops and compares whenever the DUT presents valid/done/cfg_err.
module tb_nfu_2a_ctrl;

  localparam logic [63:0] E0_L1 = {16{4'd3}};
  localparam logic [79:0] E1_L2 = {16{5'd17}};
  localparam logic [31:0] E1_WR = {16{2'd2}};

  logic         clk = 1'b0;
  logic         rst, i_cfg_we, i_start, i_step_valid;
  logic [3:0]   i_cfg_addr;
  logic [223:0] i_cfg_data;
  logic [4:0]   i_len;
  logic [7:0]   i_reps;
  logic         o_busy, o_done, o_cfg_err, o_valid;
  logic [63:0]  o_l1_sel_lines;
  logic [79:0]  o_l2_sel_lines;
  logic [31:0]  o_buf_read_addr, o_buf_write_addr;
  logic [15:0]  o_write_en;

  always #5 clk = ~clk;

  nfu_2a_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .i_cfg_we         (i_cfg_we),
    .i_cfg_addr       (i_cfg_addr),
    .i_cfg_data       (i_cfg_data),
    .i_start          (i_start),
    .i_len            (i_len),
    .i_reps           (i_reps),
    .i_step_valid     (i_step_valid),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_cfg_err        (o_cfg_err),
    .o_valid          (o_valid),
    .o_l1_sel_lines   (o_l1_sel_lines),
    .o_l2_sel_lines   (o_l2_sel_lines),
    .o_buf_read_addr  (o_buf_read_addr),
    .o_buf_write_addr (o_buf_write_addr),
    .o_write_en       (o_write_en)
  );

  typedef struct {
    logic        valid;
    logic        done;
    logic        err;
    logic        data;
    logic [63:0] l1;
    logic [79:0] l2;
    logic [31:0] rd;
    logic [31:0] wr;
    logic [15:0] we;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] m_l1 [16];
  logic [79:0] m_l2 [16];
  logic [31:0] m_rd [16];
  logic [31:0] m_wr [16];
  logic [15:0] m_we [16];
  int m_len, m_reps, m_ptr, m_rep;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t flag_exp(input logic d, input logic e);
    exp_t r;
    r.valid = 1'b0; r.done = d; r.err = e; r.data = 1'b0;
    r.l1 = '0; r.l2 = '0; r.rd = '0; r.wr = '0; r.we = '0;
    return r;
  endfunction

  task automatic cfg_write(input int a, input logic [63:0] l1, input logic [79:0] l2,
                           input logic [31:0] rd, input logic [31:0] wr,
                           input logic [15:0] we, input bit upd);
    i_cfg_we   = 1'b1;
    i_cfg_addr = 4'(a);
    i_cfg_data = {we, wr, rd, l2, l1};
    if (upd) begin
      m_l1[a] = l1; m_l2[a] = l2; m_rd[a] = rd; m_wr[a] = wr; m_we[a] = we;
    end
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic start(input int len, input int reps, input bit legal);
    i_start = 1'b1;
    i_len   = 5'(len);
    i_reps  = 8'(reps);
    if (legal) begin
      m_len = len; m_reps = reps; m_ptr = 0; m_rep = 0;
    end else begin
      q.push_back(flag_exp(1'b1, 1'b0));
    end
    tick();
    i_start = 1'b0;
  endtask

  task automatic step(input bit v);
    exp_t e;
    i_step_valid = v;
    if (v) begin
      e.valid = 1'b1;
      e.done  = (m_ptr == m_len - 1) && (m_rep == m_reps - 1);
      e.err   = 1'b0;
      e.data  = 1'b1;
      e.l1 = m_l1[m_ptr]; e.l2 = m_l2[m_ptr]; e.rd = m_rd[m_ptr];
      e.wr = m_wr[m_ptr]; e.we = m_we[m_ptr];
      q.push_back(e);
      if (m_ptr == m_len - 1) begin
        m_ptr = 0;
        m_rep++;
      end else begin
        m_ptr++;
      end
    end
    tick();
    i_step_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (o_valid === 1'b1 || o_done === 1'b1 || o_cfg_err === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got v=%b d=%b e=%b want none", o_valid, o_done, o_cfg_err);
      end else begin
        mon_e = q.pop_front();
        if (o_valid !== mon_e.valid || o_done !== mon_e.done || o_cfg_err !== mon_e.err ||
            (mon_e.data && ({o_l1_sel_lines, o_l2_sel_lines, o_buf_read_addr,
                             o_buf_write_addr, o_write_en} !==
                            {mon_e.l1, mon_e.l2, mon_e.rd, mon_e.wr, mon_e.we}))) begin
          bad++;
          $display("FAIL beat: got v=%b d=%b e=%b l1=%h l2=%h rd=%h wr=%h we=%h want v=%b d=%b e=%b l1=%h l2=%h rd=%h wr=%h we=%h",
                   o_valid, o_done, o_cfg_err, o_l1_sel_lines, o_l2_sel_lines,
                   o_buf_read_addr, o_buf_write_addr, o_write_en,
                   mon_e.valid, mon_e.done, mon_e.err, mon_e.l1, mon_e.l2,
                   mon_e.rd, mon_e.wr, mon_e.we);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    i_start = 1'b0; i_len = '0; i_reps = '0; i_step_valid = 1'b0;
    tick();
    tick();
    chk("reset_zero", {o_busy, o_done, o_cfg_err, o_valid, o_l1_sel_lines, o_l2_sel_lines,
                       o_buf_read_addr, o_buf_write_addr, o_write_en}, '0);
    rst = 1'b0;

    cfg_write(0, E0_L1, '0, '0, '0, 16'hFFFF, 1'b1);
    cfg_write(1, '0, E1_L2, '0, E1_WR, 16'h0000, 1'b1);

    // basic run
    start(2, 1, 1'b1);
    chk("busy_rise", 256'(o_busy), 256'(1));
    step(1'b1);
    chk("we_entry0", 256'(o_write_en), 256'(16'hFFFF));
    step(1'b1);
    chk("busy_at_done", 256'(o_busy), 256'(1));
    tick();
    chk("busy_fall", 256'(o_busy), 256'(0));

    // stall
    start(2, 1, 1'b1);
    step(1'b1);
    step(1'b0);
    chk("stall1_valid", 256'(o_valid), 256'(0));
    chk("stall1_we", 256'(o_write_en), 256'(0));
    chk("stall1_l1_hold", 256'(o_l1_sel_lines), 256'(E0_L1));
    step(1'b0);
    chk("stall2_we", 256'(o_write_en), 256'(0));
    chk("stall2_l1_hold", 256'(o_l1_sel_lines), 256'(E0_L1));
    step(1'b1);
    tick();

    // repetition
    start(2, 3, 1'b1);
    repeat (6) step(1'b1);
    tick();
    chk("rep_busy_fall", 256'(o_busy), 256'(0));

    // illegal starts
    start(0, 1, 1'b0);
    chk("ill_len0_busy", 256'(o_busy), 256'(0));
    chk("ill_len0_valid", 256'(o_valid), 256'(0));
    tick();
    chk("ill_len0_busy2", 256'(o_busy), 256'(0));
    start(2, 0, 1'b0);
    chk("ill_reps0_busy", 256'(o_busy), 256'(0));
    tick();
    start(17, 1, 1'b0);
    chk("ill_len17_busy", 256'(o_busy), 256'(0));
    tick();

    // config write during run
    start(2, 1, 1'b1);
    step(1'b1);
    q.push_back(flag_exp(1'b0, 1'b1));
    cfg_write(0, {16{4'hC}}, {16{5'd9}}, {16{2'd1}}, {16{2'd3}}, 16'h1234, 1'b0);
    step(1'b1);
    tick();
    start(1, 1, 1'b1);
    step(1'b1);
    chk("cfg_keep_l1", 256'(o_l1_sel_lines), 256'(E0_L1));
    tick();

    // reset mid-run
    start(2, 3, 1'b1);
    step(1'b1);
    step(1'b1);
    rst = 1'b1;
    i_step_valid = 1'b1;
    tick();
    rst = 1'b0;
    i_step_valid = 1'b0;
    chk("midrst_zero", {o_busy, o_done, o_cfg_err, o_valid, o_l1_sel_lines, o_l2_sel_lines,
                        o_buf_read_addr, o_buf_write_addr, o_write_en}, '0);
    tick();
    tick();
    chk("midrst_no_done", 256'(o_done), 256'(0));
    start(2, 1, 1'b1);
    step(1'b1);
    step(1'b1);
    tick();
    tick();

    chk("queue_drained", 256'(q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nfu_2a_ctrl.md
# nfu_2A_ctrl

Schedule sequencer that drives the control side of the NFU-2A multiplier-reuse stage. Each step it issues the per-lane L1 select lines, L2 select lines, buffer read and write addresses, and buffer write enables. It sits between the layer controller and the reuse datapath. A small schedule table is loaded over a config port, then played back one step per valid multiplier beat, for a programmable number of repetitions.

## Interface
- Tn, 16, lanes (muxes / buffers per stage)
- ADDR_SIZE, 2, per-lane buffer address width
- L1_SEL_WIDTH, 4, per-lane L1 select width
- L2_SEL_WIDTH, 5, per-lane L2 select width
- SCHED_AW, 4, schedule table address width; depth SCHED_DEPTH = 1<<SCHED_AW
- ENTRY_W, Tn*(L1_SEL_WIDTH+L2_SEL_WIDTH+2*ADDR_SIZE+1) = 224, schedule entry width

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- i_cfg_we  in  1  table write strobe
- i_cfg_addr  in  SCHED_AW  table write address
- i_cfg_data  in  ENTRY_W  entry; LSB-first fields: l1_sel [Tn*4], l2_sel [Tn*5], rd_addr [Tn*2], wr_addr [Tn*2], we [Tn]
- i_start  in  1  start pulse
- i_len  in  SCHED_AW+1  steps per pass, legal 1..SCHED_DEPTH
- i_reps  in  8  passes, legal 1..255
- i_step_valid  in  1  multiplier products valid this cycle
- o_busy  out  1  sequencer in RUN
- o_done  out  1  one-cycle completion pulse
- o_cfg_err  out  1  one-cycle pulse, config write rejected
- o_valid  out  1  control outputs carry a live step
- o_l1_sel_lines  out  Tn*L1_SEL_WIDTH
- o_l2_sel_lines  out  Tn*L2_SEL_WIDTH
- o_buf_read_addr  out  Tn*ADDR_SIZE
- o_buf_write_addr  out  Tn*ADDR_SIZE
- o_write_en  out  Tn

## Operation
- States: IDLE, RUN.
- IDLE:
  - i_cfg_we writes the table.
  - i_start with legal i_len and i_reps latches len and reps, clears ptr and rep_cnt, and enters RUN.
  - i_start with an illegal value (len=0, len>SCHED_DEPTH, or reps=0) stays in IDLE and pulses o_done on the next cycle. No step is issued.
- RUN, on a cycle with i_step_valid=1:
  - Register entry[ptr] onto the outputs and set o_valid=1.
  - If ptr==len-1, set ptr←0 and rep_cnt+1; otherwise ptr+1.
  - On the final step (ptr==len-1 and rep_cnt==reps-1), pulse o_done and return to IDLE.
- RUN, on a cycle with i_step_valid=0:
  - o_valid=0 and o_write_en=0 (forced).
  - Select lines and addresses hold their last value.
  - ptr does not advance.
- o_write_en always equals entry.we AND o_valid. The buffers are never written on a stall.
- i_cfg_we while in RUN: the write is dropped, o_cfg_err pulses next cycle, and the table is unchanged.
- i_start while in RUN: ignored.
- Reset:
  - All outputs go to 0, state to IDLE, ptr and rep_cnt to 0.
  - The table is not cleared; its power-up contents are undefined.

## Timing
- All outputs are registered.
- Step latency: i_step_valid at cycle t gives the outputs at t+1.
- The i_start cycle only latches. The earliest step is taken from i_step_valid on the cycle after start, so o_busy rises at start+1.
- o_done coincides with the final o_valid. o_busy falls the cycle after o_done.
- A table write at cycle t is readable by a step sampled at t+1 or later.
- Reset asserted mid-RUN: outputs are zero from the following cycle. Any in-flight o_done is suppressed.

## Structure
- Package nfu_2A_pkg holds:
  - Tn, ADDR_SIZE, L1_SEL_WIDTH, L2_SEL_WIDTH, ENTRY_W;
  - field offset constants (L1_OFF=0, L2_OFF=64, RD_OFF=144, WR_OFF=176, WE_OFF=208);
  - the state encoding.
- Sub-module nfu_2A_sched_mem:
  - SCHED_DEPTH×ENTRY_W register array;
  - one synchronous write port;
  - one asynchronous read port indexed by ptr.
- The top level holds the FSM, counters, output registers and write-enable gating.

## Test plan
- **Basic run:** load entry0 (all l1_sel=3, we=all 1s) and entry1 (l2_sel=17, wr_addr=2). Start with len=2, reps=1, i_step_valid high from cycle 1. Expect entry0 at cycle 2 and entry1 at cycle 3 with o_done=1 at cycle 3; o_busy=0 at cycle 4.
- **Stall:** same load, i_step_valid pattern 1,0,0,1. Expect o_valid 1,0,0,1; o_write_en=0 on the stall cycles; o_l1_sel_lines held at entry0 through the stall.
- **Repetition:** len=2, reps=3, continuous valid. Expect 6 valid steps in order 0,1,0,1,0,1 and exactly one o_done, on the 6th.
- **Illegal start:** start with len=0 (and separately reps=0). Expect o_done at start+1, no o_valid, and o_busy stays 0.
- **Config during RUN:** a cfg write to addr 0 mid-run gives o_cfg_err the next cycle. A subsequent run replays the original entry0.
- **Reset mid-run:** rst at step 3 of 6. Expect all outputs 0 and o_busy=0 the next cycle and no o_done. A restart replays the retained table correctly.
